// File: rtl/counter_load_checker.sv
// ---------------------------------------------------------------------------
// counter_load_checker
//
// Passive checker for the loadable wrap-at-MAX counter. It taps the counter's
// load/data_in stimulus and its data_out (data_obs). Every cycle it predicts
// the next counter value. One clock later it compares that prediction with
// the observed value. It then rebuilds the prediction from what it actually
// observed, so a single glitch produces exactly one error pulse.
//
// Parameters
//   WIDTH  width of counter value and data ports
//   MAX    terminal count; the observed counter goes MAX -> 0
//   CNT_W  width of err_count / wrap_count (both saturate at all-ones)
//
// Ports
//   clk         rising-edge clock
//   rst         synchronous, active-high reset (priority over all inputs)
//   chk_en      enable checking; low returns the checker to IDLE
//   load        counter load input (tapped)
//   data_in     counter load data (tapped)
//   data_obs    counter data_out (observed)
//   err         one-cycle pulse on a mismatch
//   err_count   saturating count of mismatches
//   wrap        one-cycle pulse on a correctly predicted MAX -> 0 transition
//   wrap_count  saturating count of observed wraps
//   expected    prediction for the current cycle's data_obs
//   synced      high while the checker is in CHECK
// ---------------------------------------------------------------------------
module counter_load_checker #(
    parameter int WIDTH = 4,
    parameter int MAX   = 12,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             chk_en,
    input  logic             load,
    input  logic [WIDTH-1:0] data_in,
    input  logic [WIDTH-1:0] data_obs,
    output logic             err,
    output logic [CNT_W-1:0] err_count,
    output logic             wrap,
    output logic [CNT_W-1:0] wrap_count,
    output logic [WIDTH-1:0] expected,
    output logic             synced
);

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

    typedef enum logic {
        IDLE  = 1'b0,
        CHECK = 1'b1
    } state_t;

    state_t           state;
    state_t           state_nxt;

    logic [WIDTH-1:0] expected_nxt;
    logic             err_nxt;
    logic             wrap_nxt;
    logic [CNT_W-1:0] err_count_nxt;
    logic [CNT_W-1:0] wrap_count_nxt;

    // Remembers that the prediction now held in 'expected' came from a
    // MAX base with no load, i.e. it is a genuine wrap prediction.
    logic             wrap_pend_p1;
    logic             wrap_pend_nxt;

    // Counter next-value function. Load beats the terminal-count wrap.
    // Loaded values above MAX count up and roll over through 2^WIDTH.
    function automatic logic [WIDTH-1:0] next_val(
        input logic [WIDTH-1:0] base,
        input logic             ld,
        input logic [WIDTH-1:0] din
    );
        if (ld) begin
            return din;
        end else if (base == MAX_V) begin
            return '0;
        end else begin
            return base + WIDTH'(1);
        end
    endfunction

    // Saturating increment for the event counters.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        if (&c) begin
            return c;
        end else begin
            return c + CNT_W'(1);
        end
    endfunction

    // State / output register
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            expected     <= '0;
            err          <= 1'b0;
            wrap         <= 1'b0;
            err_count    <= '0;
            wrap_count   <= '0;
            wrap_pend_p1 <= 1'b0;
        end else begin
            state        <= state_nxt;
            expected     <= expected_nxt;
            err          <= err_nxt;
            wrap         <= wrap_nxt;
            err_count    <= err_count_nxt;
            wrap_count   <= wrap_count_nxt;
            wrap_pend_p1 <= wrap_pend_nxt;
        end
    end

    // Next-state and compare logic
    always_comb begin
        state_nxt      = state;
        // The prediction is always rebuilt from the observed value, never
        // from the previous prediction, so the checker resynchronises.
        expected_nxt   = next_val(data_obs, load, data_in);
        wrap_pend_nxt  = (data_obs == MAX_V) && !load;
        err_nxt        = 1'b0;
        wrap_nxt       = 1'b0;
        err_count_nxt  = err_count;
        wrap_count_nxt = wrap_count;

        case (state)
            IDLE: begin
                if (chk_en) begin
                    state_nxt = CHECK;
                end
            end
            CHECK: begin
                if (!chk_en) begin
                    state_nxt = IDLE;
                end else if (data_obs != expected) begin
                    err_nxt       = 1'b1;
                    err_count_nxt = sat_inc(err_count);
                end else if (wrap_pend_p1 && (data_obs == '0)) begin
                    wrap_nxt       = 1'b1;
                    wrap_count_nxt = sat_inc(wrap_count);
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign synced = (state == CHECK);

endmodule

// File: tb/tb_counter_load_checker.sv
module tb_counter_load_checker;

    localparam int WIDTH = 4;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             chk_en = 1'b0;
    logic             load = 1'b0;
    logic [WIDTH-1:0] data_in = '0;
    logic [WIDTH-1:0] data_obs = '0;
    logic             err;
    logic [CNT_W-1:0] err_count;
    logic             wrap;
    logic [CNT_W-1:0] wrap_count;
    logic [WIDTH-1:0] expected;
    logic             synced;

    counter_load_checker #(.WIDTH(WIDTH), .MAX(12), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .chk_en    (chk_en),
        .load      (load),
        .data_in   (data_in),
        .data_obs  (data_obs),
        .err       (err),
        .err_count (err_count),
        .wrap      (wrap),
        .wrap_count(wrap_count),
        .expected  (expected),
        .synced    (synced)
    );

    always #5 clk = ~clk;

    // Expected outputs after one stimulus edge.
    typedef struct {
        int         id;
        logic       err;
        logic       wrap;
        logic [7:0] ec;
        logic [7:0] wc;
        logic [3:0] ex;
        logic       sy;
    } exp_t;

    // Hand-computed expectation attached to a given stimulus edge.
    // field: 0 err, 1 wrap, 2 err_count, 3 wrap_count, 4 expected, 5 synced
    typedef struct {
        int    id;
        int    field;
        int    val;
        string name;
    } hand_t;

    exp_t  exp_q[$];
    hand_t hand_q[$];

    int n_checks = 0;
    int n_fail   = 0;
    int step_id  = 0;

    // Reference state of the checker.
    logic       m_sync = 0;
    logic [3:0] m_exp  = 0;
    logic [7:0] m_ec   = 0;
    logic [7:0] m_wc   = 0;
    logic       m_err  = 0;
    logic       m_wrap = 0;
    logic       m_pend = 0;

    // Reference counter that produces correct data_obs.
    logic [3:0] cnt = 0;

    function automatic logic [3:0] fm(input logic [3:0] b, input logic l,
                                      input logic [3:0] d);
        if (l) return d;
        if (b == 4'd12) return 4'd0;
        return b + 4'd1;
    endfunction

    task automatic chk(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: sample away from the active edge and pop the scoreboard.
    exp_t  mon_e;
    hand_t mon_h;
    int    mon_act;
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            chk("err",        int'(err),        int'(mon_e.err));
            chk("wrap",       int'(wrap),       int'(mon_e.wrap));
            chk("err_count",  int'(err_count),  int'(mon_e.ec));
            chk("wrap_count", int'(wrap_count), int'(mon_e.wc));
            chk("expected",   int'(expected),   int'(mon_e.ex));
            chk("synced",     int'(synced),     int'(mon_e.sy));
            while (hand_q.size() > 0 && hand_q[0].id == mon_e.id) begin
                mon_h = hand_q.pop_front();
                case (mon_h.field)
                    0:       mon_act = int'(err);
                    1:       mon_act = int'(wrap);
                    2:       mon_act = int'(err_count);
                    3:       mon_act = int'(wrap_count);
                    4:       mon_act = int'(expected);
                    default: mon_act = int'(synced);
                endcase
                chk(mon_h.name, mon_act, mon_h.val);
            end
        end
    end

    // One clock of stimulus; model the checker and push the expectation.
    task automatic step(input logic r, input logic e, input logic l,
                        input logic [3:0] d, input logic [3:0] o);
        exp_t x;
        @(negedge clk);
        #1;
        rst = r; chk_en = e; load = l; data_in = d; data_obs = o;
        if (r) begin
            m_sync = 0; m_exp = 0; m_ec = 0; m_wc = 0;
            m_err = 0; m_wrap = 0; m_pend = 0;
        end else begin
            m_err = 0; m_wrap = 0;
            if (m_sync && e) begin
                if (o != m_exp) begin
                    m_err = 1;
                    if (m_ec != 8'hFF) m_ec = m_ec + 8'd1;
                end else if (m_pend && o == 4'd0) begin
                    m_wrap = 1;
                    if (m_wc != 8'hFF) m_wc = m_wc + 8'd1;
                end
            end
            m_exp  = fm(o, l, d);
            m_pend = (o == 4'd12) && !l;
            m_sync = e;
        end
        x.id = step_id; x.err = m_err; x.wrap = m_wrap; x.ec = m_ec;
        x.wc = m_wc; x.ex = m_exp; x.sy = m_sync;
        exp_q.push_back(x);
        step_id++;
    endtask

    task automatic hand(input int field, input int val, input string name);
        hand_t h;
        h.id = step_id - 1; h.field = field; h.val = val; h.name = name;
        hand_q.push_back(h);
    endtask

    // Step with a correctly behaving counter.
    task automatic cstep(input logic e, input logic l, input logic [3:0] d);
        step(1'b0, e, l, d, cnt);
        cnt = fm(cnt, l, d);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] o;

        // Reset
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        hand(5, 0, "rst_synced");
        hand(2, 0, "rst_err_count");
        hand(4, 0, "rst_expected");
        cnt = 0;

        // Free-running counter, 30 cycles: wraps observed at steps 13 and 26
        for (int i = 0; i < 30; i++) begin
            cstep(1, 0, 0);
            if (i == 0) hand(5, 1, "synced_after_first_edge");
            if (i == 13 || i == 26) hand(1, 1, "wrap_pulse");
            if (i == 12) hand(1, 0, "no_wrap_at_12");
        end
        hand(2, 0, "free_err_count");
        hand(3, 2, "free_wrap_count");

        // Load 5 while observing 9
        while (cnt != 4'd9) cstep(1, 0, 0);
        cstep(1, 1, 4'd5);
        hand(4, 5, "load5_expected");
        cstep(1, 0, 0);
        hand(0, 0, "load5_err");

        // Load 14: 14, 15, 0, 1 with no error and no wrap
        cstep(1, 1, 4'd14);
        cstep(1, 0, 0);
        hand(4, 15, "load14_expected");
        cstep(1, 0, 0);
        cstep(1, 0, 0);
        hand(1, 0, "no_wrap_15_to_0");
        hand(0, 0, "no_err_15_to_0");
        cstep(1, 0, 0);
        hand(2, 0, "load14_err_count");
        hand(3, 2, "load14_wrap_count");

        // Load while at MAX: load wins, no wrap
        while (cnt != 4'd12) cstep(1, 0, 0);
        cstep(1, 1, 4'd3);
        cstep(1, 0, 0);
        hand(1, 0, "load_at_max_no_wrap");
        hand(3, 2, "load_at_max_wrap_count");

        // Single glitch: 7 observed when 4 expected
        while (cnt != 4'd4) cstep(1, 0, 0);
        step(0, 1, 0, 0, 4'd7);
        hand(0, 1, "glitch_err");
        hand(2, 1, "glitch_err_count");
        hand(4, 8, "glitch_next_expected");
        cnt = 4'd8;
        cstep(1, 0, 0);
        hand(0, 0, "after_glitch_err");
        hand(2, 1, "after_glitch_err_count");

        // 300 mismatches: err_count saturates at 255
        for (int i = 0; i < 300; i++) begin
            o = cnt ^ 4'h1;
            step(0, 1, 0, 0, o);
            cnt = fm(o, 1'b0, 4'd0);
        end
        hand(2, 255, "sat_err_count");
        hand(0, 1, "sat_err");
        cstep(1, 0, 0);
        hand(2, 255, "sat_hold");
        hand(0, 0, "sat_match_err");

        // Reset mid-run with err_count = 3
        step(1, 0, 0, 0, 0);
        cnt = 0;
        hand(2, 0, "rst2_err_count");
        cstep(1, 0, 0);
        cstep(1, 0, 0);
        cstep(1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            o = cnt ^ 4'h1;
            step(0, 1, 0, 0, o);
            cnt = fm(o, 1'b0, 4'd0);
        end
        hand(2, 3, "pre_rst_err_count");
        step(1, 1, 0, 0, cnt);
        cnt = 0;
        hand(0, 0, "midrst_err");
        hand(1, 0, "midrst_wrap");
        hand(2, 0, "midrst_err_count");
        hand(3, 0, "midrst_wrap_count");
        hand(4, 0, "midrst_expected");
        hand(5, 0, "midrst_synced");

        // Disable checking for 4 cycles while corrupting data_obs
        cstep(1, 0, 0);
        cstep(1, 0, 0);
        cstep(1, 0, 0);
        for (int i = 0; i < 4; i++) begin
            o = cnt + 4'd3;
            step(0, 0, 0, 0, o);
            hand(0, 0, "disabled_err");
            cnt = fm(cnt, 1'b0, 4'd0);
        end
        hand(5, 0, "disabled_synced");
        cstep(1, 0, 0);
        hand(5, 1, "reenable_synced");
        hand(0, 0, "reenable_no_compare");
        cstep(1, 0, 0);
        hand(0, 0, "reenable_first_compare");
        hand(2, 0, "reenable_err_count");
        cstep(1, 0, 0);

        // Drain scoreboard (bounded)
        for (int i = 0; i < 10 && (exp_q.size() > 0 || hand_q.size() > 0); i++)
            @(negedge clk);
        #1;
        n_checks++;
        if (exp_q.size() != 0 || hand_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d/%0d entries left expected 0/0",
                     exp_q.size(), hand_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
